hazard_ctrl_sb: RTL and testbench

- Parametrised next-generation pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It sits beside the forwarding unit and covers the cases forwarding cannot resolve.
- Handles three hazard classes:
  - Multi-cycle load-use stalls, with configurable depth.
  - Optional WB-to-ID hazard, for when the register file has no write-through.
  - A register scoreboard for long-latency units (mul/div, slow memory) that complete out of band.
- Adds branch-redirect flush and scoreboard capacity back-pressure.

---
 rtl/hazard_ctrl_sb.sv | 220 ++++++++++++++++++++++
 tb/tb_hazard_ctrl_sb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_sb.sv
// Purpose : hazard controller for the 5-stage RV32I pipeline: load-use
//           stalls, WB-to-ID stall, and a scoreboard for out-of-band writers.
// Latency : all stall/flush outputs are combinational from the current inputs
//           and state; scoreboard and FSM updates take effect at the next edge.
// Backpressure: a long op that cannot get a scoreboard slot (full or WAW)
//           holds EX and everything upstream of it, and sends a bubble to MEM.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_pc_sel                  redirect resolved in EX (flushes ID/EX)
//   i_{ex,mem,wb}_rd_*        per-stage destination write enable / address
//   i_id_rs{1,2}_addr         ID source registers
//   i_id_opcode, i_ex_opcode  opcodes used to decide source use / loads
//   i_ex_long                 EX instruction goes to a long-latency unit
//   i_lu_done, i_lu_rd_addr   long-latency writeback
//   o_pc_enable               1 = PC advances
//   o_stall_*                 active-low, 1 = stage register loads
//   o_flush_*                 active-low, 0 = stage register loads a bubble
//   o_sb_full                 scoreboard holds MAX_PENDING writes
// Optional: define HAZARD_PERF_CNT_EN to add o_stall_cycles / o_flush_cycles.

module hazard_ctrl_sb #(
  parameter int unsigned LOAD_USE_CYC = 1,
  parameter bit          WB_BYPASS    = 1'b1,
  parameter int unsigned MAX_PENDING  = 4,
  parameter int unsigned REG_AW       = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pc_sel,
  input  logic              i_ex_rd_wren,
  input  logic              i_mem_rd_wren,
  input  logic              i_wb_rd_wren,
  input  logic [REG_AW-1:0] i_ex_rd_addr,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic [6:0]        i_id_opcode,
  input  logic [6:0]        i_ex_opcode,
  input  logic              i_ex_long,
  input  logic              i_lu_done,
  input  logic [REG_AW-1:0] i_lu_rd_addr,
  output logic              o_pc_enable,
  output logic              o_stall_id,
  output logic              o_stall_ex,
  output logic              o_stall_mem,
  output logic              o_stall_wb,
  output logic              o_flush_id,
  output logic              o_flush_ex,
  output logic              o_flush_mem,
  output logic              o_flush_wb,
  output logic              o_sb_full
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       o_stall_cycles,
  output logic [31:0]       o_flush_cycles
`endif
);

  localparam int NREG = 1 << REG_AW;
  localparam int CW   = $clog2(MAX_PENDING + 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic {IDLE, LU_STALL} lu_state_t;

  lu_state_t         state_q, state_d;
  logic [1:0]        lu_cnt_q, lu_cnt_d;
  logic [NREG-1:0]   pending_q;
  logic [CW-1:0]     pend_cnt_q;

  // MEM-stage rd is resolved by the forwarding unit; it never stalls here.
  logic unused_mem;
  assign unused_mem = i_mem_rd_wren ^ (^i_mem_rd_addr);

  // ---------------------------------------------------------------- decode
  logic rs1_used, rs2_used;
  logic rs1_live, rs2_live;
  logic ld_hit, wb_hit, sb_hit;
  logic sb_full, ex_hold, sb_set, sb_clr, sb_same;

  assign rs1_used = !((i_id_opcode == OP_LUI) || (i_id_opcode == OP_AUIPC) ||
                      (i_id_opcode == OP_JAL));
  assign rs2_used = (i_id_opcode == OP_R) || (i_id_opcode == OP_S) ||
                    (i_id_opcode == OP_B);
  assign rs1_live = rs1_used && (i_id_rs1_addr != '0);
  assign rs2_live = rs2_used && (i_id_rs2_addr != '0);

  assign ld_hit = (i_ex_opcode == OP_LOAD) && i_ex_rd_wren &&
                  ((rs1_live && (i_id_rs1_addr == i_ex_rd_addr)) ||
                   (rs2_live && (i_id_rs2_addr == i_ex_rd_addr)));

  assign wb_hit = !WB_BYPASS && i_wb_rd_wren &&
                  ((rs1_live && (i_id_rs1_addr == i_wb_rd_addr)) ||
                   (rs2_live && (i_id_rs2_addr == i_wb_rd_addr)));

  assign sb_hit = (rs1_live && pending_q[i_id_rs1_addr]) ||
                  (rs2_live && pending_q[i_id_rs2_addr]);

  // ------------------------------------------------------------ scoreboard
  assign sb_full = (pend_cnt_q == CW'(MAX_PENDING));
  // A completion this cycle frees a slot in time for the new long op.
  assign ex_hold = i_ex_long && ((sb_full && !i_lu_done) || pending_q[i_ex_rd_addr]);
  assign sb_set  = i_ex_long && i_ex_rd_wren && (i_ex_rd_addr != '0) && !ex_hold;
  assign sb_clr  = i_lu_done && pending_q[i_lu_rd_addr];
  // Set and clear of the same register: the new writer keeps the bit and
  // the count does not move.
  assign sb_same = sb_set && i_lu_done && (i_lu_rd_addr == i_ex_rd_addr);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (sb_clr && !sb_same) pending_q[i_lu_rd_addr] <= 1'b0;
      if (sb_set)             pending_q[i_ex_rd_addr] <= 1'b1;
      if (!sb_same) begin
        if (sb_set && !sb_clr)      pend_cnt_q <= pend_cnt_q + CW'(1);
        else if (!sb_set && sb_clr) pend_cnt_q <= pend_cnt_q - CW'(1);
      end
    end
  end

  // ----------------------------------------------------- load-use FSM: reg
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // ------------------------------------------------ load-use FSM: next state
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    if (i_pc_sel) begin
      state_d  = IDLE;
      lu_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_hit) begin
            lu_cnt_d = 2'(LOAD_USE_CYC - 1);
            if (LOAD_USE_CYC > 1) state_d = LU_STALL;
          end
        end
        LU_STALL: begin
          // The detect cycle was bubble #1, so leave when this is the last.
          lu_cnt_d = (lu_cnt_q == 2'd0) ? 2'd0 : lu_cnt_q - 2'd1;
          if (lu_cnt_q <= 2'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------ outputs
  logic id_stall;
  assign id_stall = (state_q == LU_STALL) || ((state_q == IDLE) && ld_hit) ||
                    wb_hit || sb_hit;

  always_comb begin
    o_pc_enable = 1'b1;
    o_stall_id  = 1'b1;
    o_stall_ex  = 1'b1;
    o_stall_mem = 1'b1;
    o_stall_wb  = 1'b1;
    o_flush_id  = 1'b1;
    o_flush_ex  = 1'b1;
    o_flush_mem = 1'b1;
    o_flush_wb  = 1'b1;
    o_sb_full   = i_rst_n && sb_full;
    if (i_rst_n) begin
      if (ex_hold) begin
        o_pc_enable = 1'b0;
        o_stall_id  = 1'b0;
        o_stall_ex  = 1'b0;
        o_flush_mem = 1'b0;
      end
      if (id_stall) begin
        o_pc_enable = 1'b0;
        o_stall_id  = 1'b0;
        // A held EX keeps its instruction; only bubble it when it moves on.
        if (!ex_hold) o_flush_ex = 1'b0;
      end
      // Redirect wins over any ID stall: the stalled instruction is dead.
      if (i_pc_sel) begin
        o_pc_enable = 1'b1;
        o_stall_id  = 1'b1;
        o_flush_id  = 1'b0;
        o_flush_ex  = 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
      o_flush_cycles <= '0;
    end else begin
      if (!o_pc_enable) o_stall_cycles <= o_stall_cycles + 32'd1;
      if (!o_flush_id)  o_flush_cycles <= o_flush_cycles + 32'd1;
    end
  end
`else
  // Performance counters compiled out; hazard behaviour is unchanged.
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed bench for hazard_ctrl_sb. Two instances share all inputs:
//   dut_a: LOAD_USE_CYC=2, WB_BYPASS=0, MAX_PENDING=2
//   dut_b: LOAD_USE_CYC=1, WB_BYPASS=1, MAX_PENDING=4
// Outputs are packed as {pc_en, stall_id, stall_ex, stall_mem, stall_wb,
// flush_id, flush_ex, flush_mem, flush_wb, sb_full}.

module tb_hazard_ctrl_sb;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;

  localparam logic [9:0] E_DEF  = 10'b1111111110;
  localparam logic [9:0] E_LU   = 10'b0011110110;
  localparam logic [9:0] E_HOLD = 10'b0001111010;
  localparam logic [9:0] E_RDR  = 10'b1111100110;
  localparam logic [9:0] E_FULL = 10'b0000000001;

  logic       i_clk, i_rst_n, i_pc_sel;
  logic       i_ex_rd_wren, i_mem_rd_wren, i_wb_rd_wren;
  logic [4:0] i_ex_rd_addr, i_mem_rd_addr, i_wb_rd_addr;
  logic [4:0] i_id_rs1_addr, i_id_rs2_addr, i_lu_rd_addr;
  logic [6:0] i_id_opcode, i_ex_opcode;
  logic       i_ex_long, i_lu_done;

  logic a_pc, a_sid, a_sex, a_smem, a_swb, a_fid, a_fex, a_fmem, a_fwb, a_full;
  logic b_pc, b_sid, b_sex, b_smem, b_swb, b_fid, b_fex, b_fmem, b_fwb, b_full;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

  logic [9:0] out_a, out_b;
  assign out_a = {a_pc, a_sid, a_sex, a_smem, a_swb, a_fid, a_fex, a_fmem, a_fwb, a_full};
  assign out_b = {b_pc, b_sid, b_sex, b_smem, b_swb, b_fid, b_fex, b_fmem, b_fwb, b_full};

  int errors = 0;
  int checks = 0;

  hazard_ctrl_sb #(.LOAD_USE_CYC(2), .WB_BYPASS(1'b0), .MAX_PENDING(2), .REG_AW(5)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_sel(i_pc_sel),
    .i_ex_rd_wren(i_ex_rd_wren), .i_mem_rd_wren(i_mem_rd_wren), .i_wb_rd_wren(i_wb_rd_wren),
    .i_ex_rd_addr(i_ex_rd_addr), .i_mem_rd_addr(i_mem_rd_addr), .i_wb_rd_addr(i_wb_rd_addr),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_opcode(i_id_opcode), .i_ex_opcode(i_ex_opcode),
    .i_ex_long(i_ex_long), .i_lu_done(i_lu_done), .i_lu_rd_addr(i_lu_rd_addr),
    .o_pc_enable(a_pc), .o_stall_id(a_sid), .o_stall_ex(a_sex), .o_stall_mem(a_smem),
    .o_stall_wb(a_swb), .o_flush_id(a_fid), .o_flush_ex(a_fex), .o_flush_mem(a_fmem),
    .o_flush_wb(a_fwb), .o_sb_full(a_full)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(a_sc), .o_flush_cycles(a_fc)
`endif
  );

  hazard_ctrl_sb #(.LOAD_USE_CYC(1), .WB_BYPASS(1'b1), .MAX_PENDING(4), .REG_AW(5)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_sel(i_pc_sel),
    .i_ex_rd_wren(i_ex_rd_wren), .i_mem_rd_wren(i_mem_rd_wren), .i_wb_rd_wren(i_wb_rd_wren),
    .i_ex_rd_addr(i_ex_rd_addr), .i_mem_rd_addr(i_mem_rd_addr), .i_wb_rd_addr(i_wb_rd_addr),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_opcode(i_id_opcode), .i_ex_opcode(i_ex_opcode),
    .i_ex_long(i_ex_long), .i_lu_done(i_lu_done), .i_lu_rd_addr(i_lu_rd_addr),
    .o_pc_enable(b_pc), .o_stall_id(b_sid), .o_stall_ex(b_sex), .o_stall_mem(b_smem),
    .o_stall_wb(b_swb), .o_flush_id(b_fid), .o_flush_ex(b_fex), .o_flush_mem(b_fmem),
    .o_flush_wb(b_fwb), .o_sb_full(b_full)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(b_sc), .o_flush_cycles(b_fc)
`endif
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) begin
    assert (!(i_pc_sel && i_ex_long)) else $error("pc_sel and ex_long both high");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ----------------------------------------------------------- stimulus
  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_pc_sel = 0; i_ex_rd_wren = 0; i_mem_rd_wren = 0; i_wb_rd_wren = 0;
    i_ex_rd_addr = 0; i_mem_rd_addr = 0; i_wb_rd_addr = 0;
    i_id_rs1_addr = 0; i_id_rs2_addr = 0; i_lu_rd_addr = 0;
    i_id_opcode = OP_I; i_ex_opcode = OP_I; i_ex_long = 0; i_lu_done = 0;
  endtask

  task automatic set_ex(input logic [6:0] op, input logic [4:0] rd,
                        input logic wren, input logic lng);
    i_ex_opcode = op; i_ex_rd_addr = rd; i_ex_rd_wren = wren; i_ex_long = lng;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
    i_id_opcode = op; i_id_rs1_addr = rs1; i_id_rs2_addr = rs2;
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    idle_in();
    nxt();
    nxt();
    i_rst_n = 1;
  endtask

  // ----------------------------------------------------------- tests
  task automatic test_reset();
    i_rst_n = 0;
    idle_in();
    set_ex(OP_LOAD, 5, 1, 0);
    set_id(OP_R, 5, 1);
    #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL rst_low_a got=%b exp=%b", out_a, E_DEF); end
    nxt();
    checks++; if (out_b !== E_DEF) begin errors++; $display("FAIL rst_low_b got=%b exp=%b", out_b, E_DEF); end
    i_rst_n = 1;
    idle_in();
    #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL rst_rel_a got=%b exp=%b", out_a, E_DEF); end
    nxt();
  endtask

  task automatic test_load_use();
    do_reset();
    set_ex(OP_LOAD, 5, 1, 0); set_id(OP_R, 5, 1); #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL lu_c0_a got=%b exp=%b", out_a, E_LU); end
    checks++; if (out_b !== E_LU) begin errors++; $display("FAIL lu_c0_b got=%b exp=%b", out_b, E_LU); end
    nxt(); set_ex(OP_I, 0, 0, 0); #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL lu_c1_a got=%b exp=%b", out_a, E_LU); end
    checks++; if (out_b !== E_DEF) begin errors++; $display("FAIL lu_c1_b got=%b exp=%b", out_b, E_DEF); end
    nxt(); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL lu_c2_a got=%b exp=%b", out_a, E_DEF); end
    // rs2 path through a store
    set_ex(OP_LOAD, 7, 1, 0); set_id(OP_S, 2, 7); #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL lu_rs2_c0 got=%b exp=%b", out_a, E_LU); end
    nxt(); set_ex(OP_I, 0, 0, 0); #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL lu_rs2_c1 got=%b exp=%b", out_a, E_LU); end
    nxt(); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL lu_rs2_c2 got=%b exp=%b", out_a, E_DEF); end
  endtask

  task automatic test_no_stall();
    do_reset();
    set_ex(OP_LOAD, 5, 1, 0);
    set_id(OP_LUI, 5, 5); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL ns_lui got=%b exp=%b", out_a, E_DEF); end
    set_id(OP_I, 0, 5); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL ns_addi_x0 got=%b exp=%b", out_a, E_DEF); end
    set_id(OP_JAL, 5, 5); #1;
    checks++; if (out_b !== E_DEF) begin errors++; $display("FAIL ns_jal got=%b exp=%b", out_b, E_DEF); end
    set_id(OP_AUIPC, 5, 5); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL ns_auipc got=%b exp=%b", out_a, E_DEF); end
    set_ex(OP_LOAD, 0, 1, 0); set_id(OP_R, 0, 0); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL ns_rd_x0 got=%b exp=%b", out_a, E_DEF); end
    set_ex(OP_LOAD, 5, 0, 0); set_id(OP_R, 5, 0); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL ns_nowren got=%b exp=%b", out_a, E_DEF); end
    set_ex(OP_LOAD, 5, 1, 0); set_id(OP_B, 1, 5); #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL ns_branch_rs2 got=%b exp=%b", out_a, E_LU); end
    nxt();
  endtask

  task automatic test_scoreboard();
    do_reset();
    set_ex(OP_R, 9, 1, 1); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL sb_issue got=%b exp=%b", out_a, E_DEF); end
    nxt(); set_ex(OP_I, 0, 0, 0); set_id(OP_R, 9, 2); #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL sb_wait0 got=%b exp=%b", out_a, E_LU); end
    nxt(); #1;
    checks++; if (out_b !== E_LU) begin errors++; $display("FAIL sb_wait1 got=%b exp=%b", out_b, E_LU); end
    i_lu_done = 1; i_lu_rd_addr = 9; #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL sb_done_cyc got=%b exp=%b", out_a, E_LU); end
    nxt(); i_lu_done = 0; #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL sb_release got=%b exp=%b", out_a, E_DEF); end
    nxt();
  endtask

  task automatic test_sb_full();
    do_reset();
    set_ex(OP_R, 3, 1, 1); nxt();
    set_ex(OP_R, 4, 1, 1); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL full_one got=%b exp=%b", out_a, E_DEF); end
    nxt(); set_ex(OP_R, 5, 1, 1); #1;
    checks++; if (out_a !== (E_HOLD | E_FULL)) begin errors++; $display("FAIL full_hold got=%b exp=%b", out_a, E_HOLD | E_FULL); end
    nxt(); #1;
    checks++; if (out_a !== (E_HOLD | E_FULL)) begin errors++; $display("FAIL full_hold2 got=%b exp=%b", out_a, E_HOLD | E_FULL); end
    i_lu_done = 1; i_lu_rd_addr = 3; #1;
    checks++; if (out_a !== (E_DEF | E_FULL)) begin errors++; $display("FAIL full_done_same got=%b exp=%b", out_a, E_DEF | E_FULL); end
    nxt(); idle_in(); #1;
    checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL full_cnt_stays got=%b exp=1", a_full); end
    i_lu_done = 1; i_lu_rd_addr = 5;
    nxt(); i_lu_done = 0; #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL full_drop got=%b exp=%b", out_a, E_DEF); end
    set_ex(OP_R, 4, 1, 1); #1;
    checks++; if (out_a !== E_HOLD) begin errors++; $display("FAIL waw_hold got=%b exp=%b", out_a, E_HOLD); end
    nxt(); idle_in(); i_lu_done = 1; i_lu_rd_addr = 3;
    nxt(); i_lu_done = 0; set_ex(OP_R, 6, 1, 1); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL clr_nonpend_issue got=%b exp=%b", out_a, E_DEF); end
    nxt(); idle_in(); #1;
    checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL clr_nonpend_full got=%b exp=1", a_full); end
    nxt();
  endtask

  task automatic test_redirect();
    do_reset();
    set_ex(OP_LOAD, 5, 1, 0); set_id(OP_R, 5, 1); i_pc_sel = 1; #1;
    checks++; if (out_a !== E_RDR) begin errors++; $display("FAIL rdr_detect got=%b exp=%b", out_a, E_RDR); end
    nxt(); set_ex(OP_I, 0, 0, 0); i_pc_sel = 0; #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL rdr_no_load got=%b exp=%b", out_a, E_DEF); end
    set_ex(OP_LOAD, 5, 1, 0); #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL rdr_lu_start got=%b exp=%b", out_a, E_LU); end
    nxt(); set_ex(OP_I, 0, 0, 0); i_pc_sel = 1; #1;
    checks++; if (out_a !== E_RDR) begin errors++; $display("FAIL rdr_mid_stall got=%b exp=%b", out_a, E_RDR); end
    nxt(); i_pc_sel = 0; set_id(OP_I, 0, 0); set_ex(OP_R, 9, 1, 1); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL rdr_after got=%b exp=%b", out_a, E_DEF); end
    nxt(); set_ex(OP_I, 0, 0, 0); set_id(OP_R, 9, 0); i_pc_sel = 1; #1;
    checks++; if (out_a !== E_RDR) begin errors++; $display("FAIL rdr_over_sb got=%b exp=%b", out_a, E_RDR); end
    nxt(); i_pc_sel = 0; #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL rdr_sb_kept got=%b exp=%b", out_a, E_LU); end
    nxt();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ex(OP_R, 3, 1, 1); nxt();
    set_ex(OP_R, 4, 1, 1); nxt();
    set_ex(OP_LOAD, 5, 1, 0); set_id(OP_R, 5, 1); #1;
    checks++; if (out_a !== (E_LU | E_FULL)) begin errors++; $display("FAIL rm_stall got=%b exp=%b", out_a, E_LU | E_FULL); end
    i_rst_n = 0; #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL rm_rst_low got=%b exp=%b", out_a, E_DEF); end
    nxt(); i_rst_n = 1; set_ex(OP_I, 0, 0, 0); set_id(OP_R, 3, 4); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL rm_after got=%b exp=%b", out_a, E_DEF); end
    nxt();
  endtask

  task automatic test_wb_hazard();
    do_reset();
    i_wb_rd_wren = 1; i_wb_rd_addr = 8; set_id(OP_S, 2, 8); #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL wb_stall_a got=%b exp=%b", out_a, E_LU); end
    checks++; if (out_b !== E_DEF) begin errors++; $display("FAIL wb_bypass_b got=%b exp=%b", out_b, E_DEF); end
    nxt(); i_wb_rd_wren = 0; #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL wb_one_cycle got=%b exp=%b", out_a, E_DEF); end
    i_wb_rd_wren = 1; set_id(OP_I, 2, 8); #1;
    checks++; if (out_a !== E_DEF) begin errors++; $display("FAIL wb_rs2_unused got=%b exp=%b", out_a, E_DEF); end
    set_id(OP_R, 8, 0); #1;
    checks++; if (out_a !== E_LU) begin errors++; $display("FAIL wb_rs1 got=%b exp=%b", out_a, E_LU); end
    nxt(); idle_in(); #1;
  endtask

  initial begin
    idle_in();
    i_rst_n = 0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_scoreboard();
    test_sb_full();
    test_redirect();
    test_reset_mid();
    test_wb_hazard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
